// File: rtl/nios_v_sram_arbiter_pkg.sv
// Shared types for the Nios V SRAM arbiter slice.
// Lock-state encodings exist only with NIOS_V_SRAM_ARB_LOCK_EN.
package nios_v_sram_arb_pkg;

    localparam int ARB_ADDR_W = 15;
    localparam int ARB_DATA_W = 32;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

`ifdef NIOS_V_SRAM_ARB_LOCK_EN
    typedef logic [1:0] lock_state_t;
    localparam lock_state_t UNLOCKED  = 2'd0;
    localparam lock_state_t LOCKED_M0 = 2'd1;
    localparam lock_state_t LOCKED_M1 = 2'd2;
`endif

endpackage

// File: rtl/nios_v_sram_arbiter_if.sv
// Avalon-MM pipelined master port as seen by the SRAM arbiter.
// The lock signal is present only with NIOS_V_SRAM_ARB_LOCK_EN.
interface nios_v_sram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
`ifdef NIOS_V_SRAM_ARB_LOCK_EN
    logic                lock;
`endif
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        input  waitrequest, readdata, readdatavalid,
        output address, byteenable, read, write, writedata
`ifdef NIOS_V_SRAM_ARB_LOCK_EN
        , output lock
`endif
    );

    modport slave (
        output waitrequest, readdata, readdatavalid,
        input  address, byteenable, read, write, writedata
`ifdef NIOS_V_SRAM_ARB_LOCK_EN
        , input lock
`endif
    );
endinterface

// File: rtl/nios_v_sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the master not granted last wins.
module nios_v_rr_arb2
    import nios_v_sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_t    last,
    input  logic       accept,
    output logic [1:0] grant,
    output master_t    next_last
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase

        next_last = last;
        if (accept && grant[0])
            next_last = M0;
        else if (accept && grant[1])
            next_last = M1;
    end

endmodule

// File: rtl/nios_v_sram_arbiter.sv
// Shares one 1-cycle-latency SRAM between the Nios V instruction and data masters.
// Define NIOS_V_SRAM_ARB_LOCK_EN to let a master hold the grant across commands.
module nios_v_sram_arbiter
    import nios_v_sram_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                reset_n,
    nios_v_sram_arbiter_if.slave m0,
    nios_v_sram_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]   sram_address,
    output logic [DATA_W/8-1:0] sram_byteenable,
    output logic                sram_chipselect,
    output logic                sram_write,
    output logic [DATA_W-1:0]   sram_writedata,
    input  logic [DATA_W-1:0]   sram_readdata
);

    logic [1:0] req;
    logic [1:0] req_elig;
    logic [1:0] grant;
    master_t    last;
    master_t    next_last;
    logic       acc_read;
    logic       rd_valid;
    master_t    rd_owner;

    assign req = {m1.read | m1.write, m0.read | m0.write};

`ifdef NIOS_V_SRAM_ARB_LOCK_EN
    lock_state_t lock_state;

    always_comb begin
        req_elig = req;
        case (lock_state)
            LOCKED_M0: req_elig[1] = 1'b0;
            LOCKED_M1: req_elig[0] = 1'b0;
            default:   req_elig = req;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_state <= UNLOCKED;
        end else begin
            case (lock_state)
                UNLOCKED: begin
                    if (grant[0] && m0.lock)
                        lock_state <= LOCKED_M0;
                    else if (grant[1] && m1.lock)
                        lock_state <= LOCKED_M1;
                end
                LOCKED_M0: if (grant[0] && !m0.lock) lock_state <= UNLOCKED;
                LOCKED_M1: if (grant[1] && !m1.lock) lock_state <= UNLOCKED;
                default:   lock_state <= UNLOCKED;
            endcase
        end
    end
`else
    assign req_elig = req;
`endif

    // The SRAM never stalls, so every grant is an accepted command.
    nios_v_rr_arb2 u_rr (
        .req       (req_elig),
        .last      (last),
        .accept    (1'b1),
        .grant     (grant),
        .next_last (next_last)
    );

    always_comb begin
        sram_address    = '0;
        sram_byteenable = '0;
        sram_writedata  = '0;
        sram_write      = 1'b0;
        if (grant[0]) begin
            sram_address    = m0.address;
            sram_byteenable = m0.byteenable;
            sram_writedata  = m0.writedata;
            sram_write      = m0.write;
        end else if (grant[1]) begin
            sram_address    = m1.address;
            sram_byteenable = m1.byteenable;
            sram_writedata  = m1.writedata;
            sram_write      = m1.write;
        end
    end

    // A command with both strobes set is a write, so it never returns data.
    assign sram_chipselect = |grant;
    assign acc_read        = sram_chipselect & ~sram_write;

    assign m0.waitrequest = ~grant[0];
    assign m1.waitrequest = ~grant[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last     <= M1;
            rd_valid <= 1'b0;
            rd_owner <= M0;
        end else begin
            last     <= next_last;
            rd_valid <= acc_read;
            if (acc_read)
                rd_owner <= master_t'(grant[1]);
        end
    end

    assign m0.readdatavalid = rd_valid & (rd_owner == M0);
    assign m1.readdatavalid = rd_valid & (rd_owner == M1);
    assign m0.readdata      = sram_readdata;
    assign m1.readdata      = sram_readdata;

endmodule

// File: tb/tb_nios_v_sram_arbiter.sv
// Bench for nios_v_sram_arbiter: directed table, hand sequences and random traffic
// checked against a transaction-level model of arbitration and memory contents.
module tb_nios_v_sram_arbiter;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        lk;
        logic [14:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
    } mcmd_t;

    typedef struct packed {
        mcmd_t       c0;
        mcmd_t       c1;
        logic        ew0;
        logic        ew1;
        logic        ev0;
        logic        ev1;
        logic        chk_d;
        logic [31:0] edata;
    } vec_t;

    typedef struct packed {
        logic        w0;
        logic        w1;
        logic        v0;
        logic        v1;
        logic [31:0] d;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [14:0] sram_address;
    logic [3:0]  sram_byteenable;
    logic        sram_chipselect;
    logic        sram_write;
    logic [31:0] sram_writedata;
    logic [31:0] sram_readdata = 32'h0;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    int          m_last;
    int          m_pend;
    logic [31:0] m_pend_data;
    int          m_lock;
    bit [31:0]   ref_mem [0:32767];
    bit [31:0]   sram_mem [0:32767];

    nios_v_sram_arbiter_if #(.ADDR_W(15), .DATA_W(32)) m0_if ();
    nios_v_sram_arbiter_if #(.ADDR_W(15), .DATA_W(32)) m1_if ();

    nios_v_sram_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m0              (m0_if),
        .m1              (m1_if),
        .sram_address    (sram_address),
        .sram_byteenable (sram_byteenable),
        .sram_chipselect (sram_chipselect),
        .sram_write      (sram_write),
        .sram_writedata  (sram_writedata),
        .sram_readdata   (sram_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro with one cycle of read latency
    always @(posedge clk) begin
        if (sram_chipselect) begin
            if (sram_write) begin
                for (int b = 0; b < 4; b++)
                    if (sram_byteenable[b])
                        sram_mem[sram_address][b*8 +: 8] <= sram_writedata[b*8 +: 8];
            end else begin
                sram_readdata <= sram_mem[sram_address];
            end
        end
    end

    function automatic mcmd_t mc(input logic rd, input logic wr, input logic lk,
                                 input logic [14:0] a, input logic [3:0] be,
                                 input logic [31:0] wd);
        mcmd_t c;
        c.rd = rd; c.wr = wr; c.lk = lk; c.a = a; c.be = be; c.wd = wd;
        return c;
    endfunction

    function automatic mcmd_t idle();
        return mc(1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
    endfunction

    function automatic mcmd_t rdc(input logic [14:0] a);
        return mc(1'b1, 1'b0, 1'b0, a, 4'hF, 32'h0);
    endfunction

    function automatic mcmd_t wrc(input logic [14:0] a, input logic [3:0] be,
                                  input logic [31:0] wd);
        return mc(1'b0, 1'b1, 1'b0, a, be, wd);
    endfunction

    function automatic vec_t mkv(input mcmd_t c0, input mcmd_t c1,
                                 input logic ew0, input logic ew1,
                                 input logic ev0, input logic ev1,
                                 input logic chk_d, input logic [31:0] edata);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.ew0 = ew0; v.ew1 = ew1;
        v.ev0 = ev0; v.ev1 = ev1; v.chk_d = chk_d; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_last = 1;
        m_pend = -1;
        m_pend_data = 32'h0;
        m_lock = -1;
    endtask

    // One bus cycle: entered and left 1 time unit after a rising edge.
    task automatic drive_cycle(input mcmd_t c0, input mcmd_t c1, output obs_t o);
        bit r0, r1;
        int win;
        mcmd_t cw;
        m0_if.read = c0.rd; m0_if.write = c0.wr; m0_if.address = c0.a;
        m0_if.byteenable = c0.be; m0_if.writedata = c0.wd;
        m1_if.read = c1.rd; m1_if.write = c1.wr; m1_if.address = c1.a;
        m1_if.byteenable = c1.be; m1_if.writedata = c1.wd;
`ifdef NIOS_V_SRAM_ARB_LOCK_EN
        m0_if.lock = c0.lk;
        m1_if.lock = c1.lk;
`endif
        r0 = c0.rd | c0.wr;
        r1 = c1.rd | c1.wr;
        if (m_lock == 0) r1 = 1'b0;
        if (m_lock == 1) r0 = 1'b0;
        if (r0 && r1)  win = (m_last == 1) ? 0 : 1;
        else if (r0)   win = 0;
        else if (r1)   win = 1;
        else           win = -1;

        #4;
        o.w0 = m0_if.waitrequest;
        o.w1 = m1_if.waitrequest;
        o.v0 = m0_if.readdatavalid;
        o.v1 = m1_if.readdatavalid;
        o.d  = o.v1 ? m1_if.readdata : m0_if.readdata;
        chk("wait_m0", {31'h0, o.w0}, {31'h0, win != 0});
        chk("wait_m1", {31'h0, o.w1}, {31'h0, win != 1});
        chk("rdv_m0", {31'h0, o.v0}, {31'h0, m_pend == 0});
        chk("rdv_m1", {31'h0, o.v1}, {31'h0, m_pend == 1});
        chk("sram_cs", {31'h0, sram_chipselect}, {31'h0, win >= 0});
        if (m_pend >= 0) chk("rdata", o.d, m_pend_data);

        m_pend = -1;
        if (win >= 0 && reset_n) begin
            cw = (win == 0) ? c0 : c1;
            m_last = win;
            if (cw.wr) ref_mem[cw.a] = merge(ref_mem[cw.a], cw.wd, cw.be);
            else begin
                m_pend = win;
                m_pend_data = ref_mem[cw.a];
            end
            if (m_lock < 0 && cw.lk) m_lock = win;
            else if (m_lock == win && !cw.lk) m_lock = -1;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [15];

    initial begin
        obs_t o;
        int n0, n1, pulses, alt_bad;

        model_reset();
        m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0;
        m0_if.byteenable = '0; m0_if.writedata = '0;
        m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0;
        m1_if.byteenable = '0; m1_if.writedata = '0;
`ifdef NIOS_V_SRAM_ARB_LOCK_EN
        m0_if.lock = 1'b0;
        m1_if.lock = 1'b0;
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) drive_cycle(idle(), idle(), o);
        reset_n = 1'b1;

        tbl[0]  = mkv(rdc(15'h10), rdc(15'h20), 0, 1, 0, 0, 0, 32'h0);
        tbl[1]  = mkv(idle(), rdc(15'h20), 1, 0, 1, 0, 1, 32'h0);
        tbl[2]  = mkv(idle(), idle(), 1, 1, 0, 1, 1, 32'h0);
        tbl[3]  = mkv(idle(), wrc(15'h7FFF, 4'hF, 32'h11223344), 1, 0, 0, 0, 0, 32'h0);
        tbl[4]  = mkv(idle(), wrc(15'h7FFF, 4'h3, 32'hDEADBEEF), 1, 0, 0, 0, 0, 32'h0);
        tbl[5]  = mkv(idle(), rdc(15'h7FFF), 1, 0, 0, 0, 0, 32'h0);
        tbl[6]  = mkv(idle(), idle(), 1, 1, 0, 1, 1, 32'h1122BEEF);
        tbl[7]  = mkv(mc(1, 1, 0, 15'h100, 4'hF, 32'h12345678), idle(), 0, 1, 0, 0, 0, 32'h0);
        tbl[8]  = mkv(idle(), idle(), 1, 1, 0, 0, 0, 32'h0);
        tbl[9]  = mkv(rdc(15'h100), idle(), 0, 1, 0, 0, 0, 32'h0);
        tbl[10] = mkv(idle(), idle(), 1, 1, 1, 0, 1, 32'h12345678);
        tbl[11] = mkv(rdc(15'h200), idle(), 0, 1, 0, 0, 0, 32'h0);
        tbl[12] = mkv(idle(), wrc(15'h200, 4'hF, 32'hCAFEF00D), 1, 0, 1, 0, 1, 32'h0);
        tbl[13] = mkv(rdc(15'h200), idle(), 0, 1, 0, 0, 0, 32'h0);
        tbl[14] = mkv(idle(), idle(), 1, 1, 1, 0, 1, 32'hCAFEF00D);

        for (int i = 0; i < 15; i++) begin
            drive_cycle(tbl[i].c0, tbl[i].c1, o);
            chk($sformatf("tbl%0d_w0", i), {31'h0, o.w0}, {31'h0, tbl[i].ew0});
            chk($sformatf("tbl%0d_w1", i), {31'h0, o.w1}, {31'h0, tbl[i].ew1});
            chk($sformatf("tbl%0d_v0", i), {31'h0, o.v0}, {31'h0, tbl[i].ev0});
            chk($sformatf("tbl%0d_v1", i), {31'h0, o.v1}, {31'h0, tbl[i].ev1});
            if (tbl[i].chk_d) chk($sformatf("tbl%0d_data", i), o.d, tbl[i].edata);
        end

        // Both masters stream 8 reads; m0 was granted last, so m1 leads.
        n0 = 0; n1 = 0; pulses = 0; alt_bad = 0;
        for (int k = 0; k < 17; k++) begin
            drive_cycle(n0 < 8 ? rdc(15'(15'h300 + n0)) : idle(),
                        n1 < 8 ? rdc(15'(15'h400 + n1)) : idle(), o);
            if (o.v0 || o.v1) pulses++;
            if (k < 16) begin
                if ((k % 2 == 0) ? o.w1 : o.w0) alt_bad++;
                if (!o.w0 && !o.w1) alt_bad++;
            end
            if (!o.w0 && n0 < 8) n0++;
            if (!o.w1 && n1 < 8) n1++;
        end
        chk("stream_pulses", pulses, 16);
        chk("stream_alternate", alt_bad, 0);
        chk("stream_m0_count", n0, 8);
        chk("stream_m1_count", n1, 8);

        // Reset lands in the cycle after an accepted read.
        drive_cycle(rdc(15'h300), idle(), o);
        reset_n = 1'b0;
        #1;
        chk("rst_rdv_m0", {31'h0, m0_if.readdatavalid}, 32'h0);
        chk("rst_rdv_m1", {31'h0, m1_if.readdatavalid}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        drive_cycle(idle(), idle(), o);
        reset_n = 1'b1;
        drive_cycle(rdc(15'h10), rdc(15'h20), o);
        chk("rst_tie_m0_wins", {30'h0, o.w0, o.w1}, 32'h1);
        drive_cycle(idle(), rdc(15'h20), o);
        drive_cycle(idle(), idle(), o);

`ifdef NIOS_V_SRAM_ARB_LOCK_EN
        drive_cycle(idle(), mc(1, 0, 1, 15'h40, 4'hF, 32'h0), o);
        chk("lock_take_w1", {31'h0, o.w1}, 32'h0);
        drive_cycle(rdc(15'h41), idle(), o);
        chk("lock_hold1_w0", {31'h0, o.w0}, 32'h1);
        drive_cycle(rdc(15'h41), idle(), o);
        chk("lock_hold2_w0", {31'h0, o.w0}, 32'h1);
        drive_cycle(rdc(15'h41), wrc(15'h40, 4'hF, 32'h0BADF00D), o);
        chk("lock_unlock_w0", {31'h0, o.w0}, 32'h1);
        chk("lock_unlock_w1", {31'h0, o.w1}, 32'h0);
        drive_cycle(rdc(15'h41), idle(), o);
        chk("lock_release_w0", {31'h0, o.w0}, 32'h0);
        drive_cycle(idle(), idle(), o);
`endif

        for (int k = 0; k < 400; k++) begin
            mcmd_t r0c, r1c;
            int s0, s1;
            s0 = int'($urandom_range(0, 3));
            s1 = int'($urandom_range(0, 3));
            r0c = mc(s0[0], s0[1], 1'b0, 15'($urandom_range(0, 15)),
                     4'($urandom_range(1, 15)), $urandom);
            r1c = mc(s1[0], s1[1], 1'b0, 15'($urandom_range(0, 15)),
                     4'($urandom_range(1, 15)), $urandom);
            drive_cycle(r0c, r1c, o);
        end
        drive_cycle(idle(), idle(), o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nios_v_sram_arbiter.md
# nios_v_sram_arbiter

Two-port arbiter sharing the single-port 32K×32 on-chip SRAM between the Nios V instruction-fetch master (m0) and data master (m1). Accepts Avalon-MM pipelined commands from both masters and grants one per cycle using round-robin. Drives the SRAM command port and routes the 1-cycle-latency read data back to the owning master. Sits between the CPU bus masters and the SRAM macro.

## Interface
- ADDR_W, 15, word address width; SRAM depth is 2^ADDR_W.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- mN_address  in  ADDR_W  word address (N = 0, 1).
- mN_byteenable  in  DATA_W/8  write byte lanes.
- mN_read / mN_write  in  1  command strobes.
- mN_writedata  in  DATA_W  write data.
- mN_lock  in  1  hold grant after this command (only with NIOS_V_SRAM_ARB_LOCK_EN).
- mN_waitrequest  out  1  command not accepted this cycle.
- mN_readdata  out  DATA_W  read data.
- mN_readdatavalid  out  1  mN_readdata valid this cycle.
- sram_address  out  ADDR_W  to SRAM address.
- sram_byteenable  out  DATA_W/8  to SRAM byteenable.
- sram_chipselect / sram_write  out  1  to SRAM chipselect / write.
- sram_writedata  out  DATA_W  to SRAM writedata.
- sram_readdata  in  DATA_W  from SRAM readdata.

## Operation
- Request: reqN = mN_read | mN_write. If both strobes set, treated as write; read ignored.
- Grant (combinational): only one requester -> it wins. Both -> the master not granted last (rr pointer `last`). Grant of a master updates `last` at clock edge on acceptance only.
- Accepted command: mN_waitrequest = 0 for granted master, 1 for the other requester and 1 for any master while idle is irrelevant (drive 1 when not granted).
- SRAM drive: sram_chipselect = any grant; sram_write = granted write; address/byteenable/writedata muxed from granted master; zeros when idle.
- Read return: registered rd_valid + rd_owner captured on accepted read; mN_readdatavalid = rd_valid & (rd_owner==N); mN_readdata = sram_readdata for both masters (only meaningful when valid).
- Writes produce no response.
- Reset values: `last` = m1 (m0 wins first tie), rd_valid = 0, lock state UNLOCKED; all mN_readdatavalid = 0; waitrequests follow grant logic (both 1 with no requests).

## Timing
- Command accepted in cycle T (req & ~waitrequest); SRAM registers it at end of T.
- Read data and readdatavalid in cycle T+1; fixed latency 1, back-to-back reads every cycle supported, one outstanding per cycle.
- Alternating contention: m0 and m1 both requesting continuously -> grants alternate m0, m1, m0, ... 100% SRAM utilisation.
- Read at T then write same address at T+1: read returns old data.
- Reset asserted mid-read: rd_valid cleared asynchronously; no readdatavalid issued for that read.

## Configuration
- NIOS_V_SRAM_ARB_LOCK_EN defined: mN_lock ports exist; lock FSM states UNLOCKED, LOCKED_M0, LOCKED_M1. UNLOCKED -> LOCKED_MN on accepted command from N with mN_lock=1. LOCKED_MN -> UNLOCKED on accepted command from N with mN_lock=0. While LOCKED_MN, only N may be granted; other master waits; `last` still updates.
- Undefined: no lock ports, no FSM, pure round-robin.

## Structure
- Package nios_v_sram_arb_pkg: ADDR_W/DATA_W defaults, master index typedef (M0, M1), lock state enum.
- Sub-module nios_v_rr_arb2: 2-way round-robin picker (req[1:0], last, accept -> grant[1:0], next last).

## Test plan
- Out of reset, m0 read addr 0x0010 and m1 read addr 0x0020 same cycle -> m0 granted T, m1 T+1; m0_readdatavalid at T+1, m1_readdatavalid at T+2 with correct words.
- m1 write 0xDEADBEEF to 0x7FFF, byteenable 0x3, then read -> returns 0x????BEEF with upper bytes preserved from prior value.
- Both masters stream 8 reads continuously -> grants strictly alternate, 16 readdatavalid pulses in 16 cycles, each to correct owner.
- m0 asserts read and write together at 0x0100 -> write performed, no readdatavalid.
- reset_n deasserted low during cycle after accepted read -> no readdatavalid; after release m0 wins first tie.
- LOCK_EN: m1 read with m1_lock=1, then m0 requests 3 cycles while m1 writes with lock=0 at cycle 3 -> m0 waitrequest high until m1 unlock write accepted, m0 granted next cycle.
